// File: rtl/mor1kx_exec_commit_marocchino_if.sv
// mor1kx_exec_commit_marocchino_if: execute-result and writeback channels of the commit buffer
interface mor1kx_exec_commit_marocchino_if #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5,
   parameter int FPCSR_EXC_WIDTH      = 8
);
   logic                            exec_valid_i;
   logic                            exec_ready_o;
   logic [OPTION_OPERAND_WIDTH-1:0] exec_result_i;
   logic [OPTION_RF_ADDR_WIDTH-1:0] exec_rfd_adr_i;
   logic                            exec_rf_wb_i;
   logic                            exec_flag_set_i;
   logic                            exec_flag_clear_i;
   logic                            exec_carry_set_i;
   logic                            exec_carry_clear_i;
   logic                            exec_overflow_set_i;
   logic                            exec_overflow_clear_i;
   logic [FPCSR_EXC_WIDTH-1:0]      exec_fpcsr_i;
   logic                            exec_fpcsr_set_i;
   logic                            wb_valid_o;
   logic                            wb_ready_i;
   logic [OPTION_OPERAND_WIDTH-1:0] wb_result_o;
   logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_o;
   logic                            wb_rf_we_o;
   modport master (
      output exec_valid_i, exec_result_i, exec_rfd_adr_i, exec_rf_wb_i,
             exec_flag_set_i, exec_flag_clear_i, exec_carry_set_i, exec_carry_clear_i,
             exec_overflow_set_i, exec_overflow_clear_i, exec_fpcsr_i, exec_fpcsr_set_i,
             wb_ready_i,
      input  exec_ready_o, wb_valid_o, wb_result_o, wb_rfd_adr_o, wb_rf_we_o
   );
   modport slave (
      input  exec_valid_i, exec_result_i, exec_rfd_adr_i, exec_rf_wb_i,
             exec_flag_set_i, exec_flag_clear_i, exec_carry_set_i, exec_carry_clear_i,
             exec_overflow_set_i, exec_overflow_clear_i, exec_fpcsr_i, exec_fpcsr_set_i,
             wb_ready_i,
      output exec_ready_o, wb_valid_o, wb_result_o, wb_rfd_adr_o, wb_rf_we_o
   );
endinterface

// File: rtl/mor1kx_exec_commit_marocchino.sv
// mor1kx_exec_commit_marocchino: 2-entry execute-result skid buffer committing GPR, SR[F/CY/OV] and sticky FPCSR
// Optional MOR1KX_COMMIT_BYPASS_EN adds a youngest-match forwarding port from the buffered entries.
module mor1kx_exec_commit_marocchino #(
   parameter int OPTION_OPERAND_WIDTH = 32,
   parameter int OPTION_RF_ADDR_WIDTH = 5,
   parameter int FPCSR_EXC_WIDTH      = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pipeline_flush_i,
   input  logic                            fpcsr_clear_i,
   mor1kx_exec_commit_marocchino_if.slave  x,
   output logic                            flag_o,
   output logic                            carry_o,
   output logic                            overflow_o,
`ifdef MOR1KX_COMMIT_BYPASS_EN
   input  logic [OPTION_RF_ADDR_WIDTH-1:0] byp_adr_i,
   output logic                            byp_hit_o,
   output logic [OPTION_OPERAND_WIDTH-1:0] byp_data_o,
`endif
   output logic [FPCSR_EXC_WIDTH-1:0]      fpcsr_exc_o
);
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   typedef struct packed {
      logic [OPTION_OPERAND_WIDTH-1:0] res;
      logic [OPTION_RF_ADDR_WIDTH-1:0] adr;
      logic                            wb;
      logic                            fs, fc, cs, cc, os, oc;
      logic [FPCSR_EXC_WIDTH-1:0]      fpc;
      logic                            fps;
   } ent_t;

   state_t                     state_q, state_d;
   logic                       hd_q, tl_q, accept, commit;
   logic                       flag_q, carry_q, ovf_q;
   logic [FPCSR_EXC_WIDTH-1:0] fpcsr_q;
   ent_t                       ent_q [2];
   ent_t                       h;

   assign h              = ent_q[hd_q];
   assign x.exec_ready_o = state_q != FULL;
   assign x.wb_valid_o   = state_q != EMPTY;
   assign accept         = x.exec_valid_i & x.exec_ready_o & ~pipeline_flush_i;
   assign commit         = x.wb_valid_o & x.wb_ready_i & ~pipeline_flush_i;
   assign x.wb_result_o  = h.res;
   assign x.wb_rfd_adr_o = h.adr;
   assign x.wb_rf_we_o   = commit & h.wb & (|h.adr);
   assign flag_o         = flag_q;
   assign carry_o        = carry_q;
   assign overflow_o     = ovf_q;
   assign fpcsr_exc_o    = fpcsr_q;

   always_comb begin
      state_d = state_q;
      state_d = pipeline_flush_i      ? EMPTY :
                (accept & ~commit)    ? (state_q == EMPTY ? ONE : FULL) :
                (commit & ~accept)    ? (state_q == FULL ? ONE : EMPTY) :
                                        state_q;
   end

   always_ff @(posedge clk) begin
      state_q <= rst ? EMPTY : state_d;
      hd_q    <= (rst | pipeline_flush_i) ? 1'b0 : hd_q ^ commit;
      tl_q    <= (rst | pipeline_flush_i) ? 1'b0 : tl_q ^ accept;
   end

   // payload storage is deliberately left unreset; only occupancy qualifies it
   always_ff @(posedge clk) begin
      if (accept)
         ent_q[tl_q] <= {x.exec_result_i, x.exec_rfd_adr_i, x.exec_rf_wb_i,
                         x.exec_flag_set_i, x.exec_flag_clear_i, x.exec_carry_set_i,
                         x.exec_carry_clear_i, x.exec_overflow_set_i, x.exec_overflow_clear_i,
                         x.exec_fpcsr_i, x.exec_fpcsr_set_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flag_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         fpcsr_q <= '0;
      end else begin
         flag_q  <= commit ? h.fs | (flag_q & ~h.fc) : flag_q;
         carry_q <= commit ? h.cs | (carry_q & ~h.cc) : carry_q;
         ovf_q   <= commit ? h.os | (ovf_q & ~h.oc) : ovf_q;
         fpcsr_q <= fpcsr_clear_i ? '0 : (commit & h.fps) ? fpcsr_q | h.fpc : fpcsr_q;
      end
   end

`ifdef MOR1KX_COMMIT_BYPASS_EN
   logic [1:0] vld, m;
   logic       yg;
   assign yg  = ~hd_q;
   assign vld = {(state_q == FULL) | ((state_q == ONE) & hd_q),
                 (state_q == FULL) | ((state_q == ONE) & ~hd_q)};
   assign m   = {vld[1] & ent_q[1].wb & (ent_q[1].adr == byp_adr_i),
                 vld[0] & ent_q[0].wb & (ent_q[0].adr == byp_adr_i)};
   assign byp_hit_o  = (|m) & (|byp_adr_i);
   assign byp_data_o = m[yg] ? ent_q[yg].res : ent_q[hd_q].res;
`endif
endmodule

// File: tb/tb_mor1kx_exec_commit_marocchino.sv
// tb_mor1kx_exec_commit_marocchino: directed checks of ordering, backpressure, SR/FPCSR commit and flush
module tb_mor1kx_exec_commit_marocchino;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic       fclr = 1'b0;
   logic       flag, carry, ovf;
   logic [7:0] fpcsr;
   int         n_cmp = 0;
   int         n_err = 0;
`ifdef MOR1KX_COMMIT_BYPASS_EN
   logic [4:0]  byp_adr = '0;
   logic        byp_hit;
   logic [31:0] byp_data;
`endif

   mor1kx_exec_commit_marocchino_if ci ();

   mor1kx_exec_commit_marocchino dut (
      .clk              (clk),
      .rst              (rst),
      .pipeline_flush_i (flush),
      .fpcsr_clear_i    (fclr),
      .x                (ci.slave),
      .flag_o           (flag),
      .carry_o          (carry),
      .overflow_o       (ovf),
`ifdef MOR1KX_COMMIT_BYPASS_EN
      .byp_adr_i        (byp_adr),
      .byp_hit_o        (byp_hit),
      .byp_data_o       (byp_data),
`endif
      .fpcsr_exc_o      (fpcsr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // sr = {flag_set, flag_clear, carry_set, carry_clear, ovf_set, ovf_clear}
   task automatic drv(input logic v, input logic [31:0] r, input logic [4:0] a, input logic w,
                      input logic [5:0] sr, input logic [7:0] fp, input logic fps);
      ci.exec_valid_i = v;
      ci.exec_result_i = r;
      ci.exec_rfd_adr_i = a;
      ci.exec_rf_wb_i = w;
      {ci.exec_flag_set_i, ci.exec_flag_clear_i, ci.exec_carry_set_i,
       ci.exec_carry_clear_i, ci.exec_overflow_set_i, ci.exec_overflow_clear_i} = sr;
      ci.exec_fpcsr_i = fp;
      ci.exec_fpcsr_set_i = fps;
   endtask

   initial begin
      drv(0, 0, 0, 0, 0, 0, 0);
      ci.wb_ready_i = 1'b0;
      step();
      step();
      rst = 1'b0;
      #1;
      chk("rst_valid", ci.wb_valid_o, 0);
      chk("rst_ready", ci.exec_ready_o, 1);
      chk("rst_flag", flag, 0);
      chk("rst_carry", carry, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_fpcsr", fpcsr, 0);

      drv(1, 32'h1234, 3, 1, 0, 0, 0);
      ci.wb_ready_i = 1'b1;
      #1;
      chk("no_passthru_valid", ci.wb_valid_o, 0);
      chk("no_passthru_we", ci.wb_rf_we_o, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("t1_valid", ci.wb_valid_o, 1);
      chk("t1_we", ci.wb_rf_we_o, 1);
      chk("t1_res", ci.wb_result_o, 32'h1234);
      chk("t1_adr", ci.wb_rfd_adr_o, 3);
      step();
      chk("t1_empty", ci.wb_valid_o, 0);

      ci.wb_ready_i = 1'b0;
      drv(1, 32'hA, 1, 1, 0, 0, 0);
      step();
      drv(1, 32'hB, 2, 1, 0, 0, 0);
      step();
      chk("full_ready", ci.exec_ready_o, 0);
      chk("full_head", ci.wb_result_o, 32'hA);
      chk("full_we_stall", ci.wb_rf_we_o, 0);
      drv(1, 32'hC, 4, 1, 0, 0, 0);
      step();
      chk("held_head", ci.wb_result_o, 32'hA);
      chk("held_ready", ci.exec_ready_o, 0);
      ci.wb_ready_i = 1'b1;
      #1;
      chk("commitA_we", ci.wb_rf_we_o, 1);
      step();
      chk("after_A_ready", ci.exec_ready_o, 1);
      chk("order_B", ci.wb_result_o, 32'hB);
      chk("order_B_adr", ci.wb_rfd_adr_o, 2);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("order_C", ci.wb_result_o, 32'hC);
      chk("order_C_valid", ci.wb_valid_o, 1);
      step();
      chk("drain_empty", ci.wb_valid_o, 0);

      ci.wb_ready_i = 1'b0;
      drv(1, 32'h55, 0, 1, 6'b111000, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("sr_before_flag", flag, 0);
      chk("sr_before_carry", carry, 0);
      ci.wb_ready_i = 1'b1;
      #1;
      chk("r0_we_suppr", ci.wb_rf_we_o, 0);
      step();
      chk("sr_flag_set_prio", flag, 1);
      chk("sr_carry_set", carry, 1);
      drv(1, 32'h66, 6, 1, 6'b010010, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("sr_flag_hold", flag, 1);
      step();
      chk("sr_flag_clr", flag, 0);
      chk("sr_carry_hold", carry, 1);
      chk("sr_ovf_set", ovf, 1);

      drv(1, 0, 1, 1, 0, 8'h01, 1);
      step();
      drv(1, 0, 1, 1, 0, 8'h04, 1);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("fp_first", fpcsr, 8'h01);
      step();
      chk("fp_or", fpcsr, 8'h05);
      drv(1, 0, 1, 1, 0, 8'h80, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("fp_noset", fpcsr, 8'h05);
      drv(1, 0, 1, 1, 0, 8'h02, 1);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      fclr = 1'b1;
      step();
      fclr = 1'b0;
      chk("fp_clr_wins", fpcsr, 8'h00);
      chk("fp_drained", ci.wb_valid_o, 0);

      drv(1, 0, 1, 1, 6'b100000, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("pre_flush_flag", flag, 1);
      ci.wb_ready_i = 1'b0;
      drv(1, 32'h77, 7, 1, 6'b010000, 8'h10, 1);
      step();
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      chk("pre_flush_full", ci.exec_ready_o, 0);
      ci.wb_ready_i = 1'b1;
      flush = 1'b1;
      #1;
      chk("flush_we", ci.wb_rf_we_o, 0);
      step();
      flush = 1'b0;
      ci.wb_ready_i = 1'b0;
      chk("flush_valid", ci.wb_valid_o, 0);
      chk("flush_ready", ci.exec_ready_o, 1);
      chk("flush_flag", flag, 1);
      chk("flush_fpcsr", fpcsr, 0);

`ifdef MOR1KX_COMMIT_BYPASS_EN
      drv(1, 32'h11, 5, 1, 0, 0, 0);
      step();
      drv(1, 32'h22, 5, 1, 0, 0, 0);
      step();
      drv(0, 0, 0, 0, 0, 0, 0);
      byp_adr = 5;
      #1;
      chk("byp_hit", byp_hit, 1);
      chk("byp_young", byp_data, 32'h22);
      byp_adr = 0;
      #1;
      chk("byp_r0", byp_hit, 0);
      byp_adr = 6;
      #1;
      chk("byp_miss", byp_hit, 0);
      ci.wb_ready_i = 1'b1;
      step();
      ci.wb_ready_i = 1'b0;
      byp_adr = 5;
      #1;
      chk("byp_one_hit", byp_hit, 1);
      chk("byp_one_data", byp_data, 32'h22);
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("byp_empty", byp_hit, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule

// File: doc/mor1kx_exec_commit_marocchino.md
Name: mor1kx_exec_commit_marocchino

Overview:
Receiving end of the MAROCCHINO execute-stage result interface. It captures the un-latched execute outputs (result, destination, SR flag, carry and overflow set/clear strobes, FPCSR update) into a 2-entry FIFO/skid buffer with valid/ready handshakes on both sides. On commit (FIFO head leaves toward the register file) it drives the GPR write and updates the architectural SR[F], SR[CY], SR[OV] and the sticky FPCSR exception bits. It sits between the execute unit and the RF write port, decoupling multi-cycle units (mul, div, FPU, LSU) from writeback stalls.

Parameters:
OPTION_OPERAND_WIDTH, 32, result/data width
OPTION_RF_ADDR_WIDTH, 5, GPR address width
FPCSR_EXC_WIDTH, 8, width of sticky FPCSR exception field

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
pipeline_flush_i  in  1  drop all buffered entries
exec_valid_i  in  1  execute result valid
exec_ready_o  out  1  buffer can accept (not full)
exec_result_i  in  OPTION_OPERAND_WIDTH  execute result
exec_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  destination GPR
exec_rf_wb_i  in  1  instruction writes GPR
exec_flag_set_i / exec_flag_clear_i  in  1 each  SR[F] strobes
exec_carry_set_i / exec_carry_clear_i  in  1 each  SR[CY] strobes
exec_overflow_set_i / exec_overflow_clear_i  in  1 each  SR[OV] strobes
exec_fpcsr_i  in  FPCSR_EXC_WIDTH  FPU exception bits
exec_fpcsr_set_i  in  1  FPU exception bits valid
fpcsr_clear_i  in  1  software clear of sticky FPCSR bits
wb_valid_o  out  1  head entry valid
wb_ready_i  in  1  RF write side accepts head
wb_result_o  out  OPTION_OPERAND_WIDTH  head result
wb_rfd_adr_o  out  OPTION_RF_ADDR_WIDTH  head destination
wb_rf_we_o  out  1  GPR write strobe = commit & head rf_wb & rfd!=0
flag_o / carry_o / overflow_o  out  1 each  architectural SR bits
fpcsr_exc_o  out  FPCSR_EXC_WIDTH  sticky FPU exception bits

Behaviour:
- Occupancy count 0/1/2 (states EMPTY, ONE, FULL); entries head/tail by 1-bit pointers, wrap modulo 2.
- exec_ready_o = (count != FULL); depends on registered state only, never on wb_ready_i.
- accept = exec_valid_i & exec_ready_o; commit = wb_valid_o & wb_ready_i; wb_valid_o = (count != EMPTY).
- Latency: entry accepted in cycle N is visible at wb_* in N+1 earliest; no same-cycle pass-through.
- EMPTY: accept -> ONE. ONE: accept&commit -> ONE (new entry becomes head); accept only -> FULL; commit only -> EMPTY. FULL: commit -> ONE; accept impossible.
- wb_result_o/wb_rfd_adr_o hold head contents while wb_ready_i low; stable until commit.
- wb_rf_we_o asserted only in the commit cycle; suppressed for rfd==0.
- SR updates on commit only, from head strobes: set has priority over clear if both asserted; neither asserted -> hold.
- fpcsr_exc_o |= head fpcsr bits on commit when head fpcsr_set; fpcsr_clear_i in same cycle wins over commit OR (result = 0).
- pipeline_flush_i: count -> EMPTY next cycle, no commit that cycle (wb_rf_we_o forced 0, SR/FPCSR not updated), accept ignored; SR/FPCSR hold.
- rst: count EMPTY, pointers 0, flag_o=0, carry_o=0, overflow_o=0, fpcsr_exc_o=0, wb_valid_o=0, exec_ready_o=1 from next cycle; wb_result_o/wb_rfd_adr_o don't-care (data regs not reset). Reset mid-operation discards entries as flush.

Optional Feature:
MOR1KX_COMMIT_BYPASS_EN: adds ports byp_adr_i (OPTION_RF_ADDR_WIDTH, in), byp_hit_o (1, out), byp_data_o (OPTION_OPERAND_WIDTH, out). byp_hit_o=1 when any valid rf_wb entry has rfd==byp_adr_i and byp_adr_i!=0; byp_data_o = youngest matching entry (tail-most) result; combinational from registered buffer. Without macro: ports absent, no bypass logic.

Test Plan:
- Reset, then exec_valid_i=1 result 0x1234 rfd=3 rf_wb=1, wb_ready_i=1 -> next cycle wb_valid_o=1, wb_rf_we_o=1, wb_result_o=0x1234, wb_rfd_adr_o=3.
- wb_ready_i=0, push 0xA then 0xB -> exec_ready_o=0 after 2nd accept; third push held; raise wb_ready_i -> commits 0xA then 0xB in order, exec_ready_o=1 after first commit.
- Entry with flag_set=1 and flag_clear=1, carry_set=1 -> on commit flag_o=1, carry_o=1; later entry flag_clear=1 -> flag_o=0; SR unchanged before commit cycle.
- Two entries fpcsr 0x01 and 0x04 committed -> fpcsr_exc_o=0x05; fpcsr_clear_i with third commit 0x02 -> 0x00.
- FULL buffer, pipeline_flush_i=1 with wb_ready_i=1 -> no wb_rf_we_o, next cycle wb_valid_o=0, exec_ready_o=1, flag_o unchanged.
- (BYPASS_EN) entries rfd=5 data 0x11 (head), rfd=5 data 0x22 (tail), byp_adr_i=5 -> byp_hit_o=1, byp_data_o=0x22; byp_adr_i=0 -> byp_hit_o=0.
